decode_stage: RTL and testbench

//  Pipelined RV64IM instruction decoder; the producing end of the ALU op-code interface.

---
 rtl/decode_stage.sv | 261 ++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV64IM decode stage: one-entry pipeline register between fetch and execute.
// Emits ALU op code, register indices, immediate, shamt and PC.
module decode_stage #(
  parameter int unsigned XLEN   = 64,
  parameter logic [7:0]  ILL_OP = 8'd255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_op,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_shamt,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal,
  output logic [15:0]     ill_count
);

  typedef struct packed {
    logic [7:0]      op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] shamt;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } id_ex_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
  localparam logic [6:0] OPC_OPW    = 7'b0111011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  logic [31:0]     i;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] sh6, sh5;
  logic            sh_ok;
  logic            ok;
  id_ex_t          d, q;

  assign i   = in_instr;
  assign opc = i[6:0];
  assign f3  = i[14:12];
  assign f7  = i[31:25];

  assign imm_i = {{(XLEN-12){i[31]}}, i[31:20]};
  assign imm_s = {{(XLEN-12){i[31]}}, i[31:25], i[11:7]};
  assign imm_b = {{(XLEN-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){i[31]}}, i[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  assign sh6   = {{(XLEN-6){1'b0}}, i[25:20]};
  assign sh5   = {{(XLEN-5){1'b0}}, i[24:20]};
  assign sh_ok = (i[31:26] == 6'b000000) || (i[31:26] == 6'b010000);

  always_comb begin
    ok      = 1'b1;
    d       = '0;
    d.op    = ILL_OP;
    d.rd    = i[11:7];
    d.rs1   = i[19:15];
    d.pc    = in_pc;
    unique case (opc)
      OPC_OP: begin
        d.rs2 = i[24:20];
        case (f7)
          7'h00: begin
            case (f3)
              3'd0: d.op = 8'd0;
              3'd1: d.op = 8'd5;
              3'd2: d.op = 8'd8;
              3'd3: d.op = 8'd9;
              3'd4: d.op = 8'd2;
              3'd5: d.op = 8'd6;
              3'd6: d.op = 8'd3;
              default: d.op = 8'd4;
            endcase
          end
          7'h20: begin
            if (f3 == 3'd0) d.op = 8'd1;
            else if (f3 == 3'd5) d.op = 8'd7;
            else ok = 1'b0;
          end
          7'h01: d.op = 8'd10 + {5'd0, f3};
          default: ok = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        d.imm = imm_i;
        case (f3)
          3'd0: d.op = 8'd18;
          3'd1: begin
            d.op = 8'd22;
            d.shamt = sh6;
            ok = sh_ok;
          end
          3'd2: d.op = 8'd25;
          3'd3: d.op = 8'd26;
          3'd4: d.op = 8'd19;
          3'd5: begin
            d.op = i[30] ? 8'd24 : 8'd23;
            d.shamt = sh6;
            ok = sh_ok;
          end
          3'd6: d.op = 8'd20;
          default: d.op = 8'd21;
        endcase
      end
      OPC_OPIMMW: begin
        d.imm = imm_i;
        case (f3)
          3'd0: d.op = 8'd29;
          3'd1: begin
            d.op = 8'd30;
            d.shamt = sh5;
            ok = !i[25];
          end
          3'd5: begin
            d.op = i[30] ? 8'd32 : 8'd31;
            d.shamt = sh5;
            ok = !i[25];
          end
          default: ok = 1'b0;
        endcase
      end
      OPC_OPW: begin
        d.rs2 = i[24:20];
        case ({f7, f3})
          {7'h00, 3'd0}: d.op = 8'd33;
          {7'h00, 3'd1}: d.op = 8'd35;
          {7'h00, 3'd5}: d.op = 8'd36;
          {7'h20, 3'd0}: d.op = 8'd34;
          {7'h20, 3'd5}: d.op = 8'd37;
          {7'h01, 3'd0}: d.op = 8'd38;
          {7'h01, 3'd4}: d.op = 8'd39;
          {7'h01, 3'd5}: d.op = 8'd40;
          {7'h01, 3'd6}: d.op = 8'd41;
          {7'h01, 3'd7}: d.op = 8'd42;
          default: ok = 1'b0;
        endcase
      end
      OPC_STORE: begin
        d.rd  = 5'd0;
        d.rs2 = i[24:20];
        d.imm = imm_s;
        d.op  = 8'd43 + {6'd0, f3[1:0]};
        ok    = !f3[2];
      end
      OPC_BRANCH: begin
        d.rd  = 5'd0;
        d.rs2 = i[24:20];
        d.imm = imm_b;
        case (f3)
          3'd0: d.op = 8'd47;
          3'd1: d.op = 8'd48;
          3'd4: d.op = 8'd49;
          3'd5: d.op = 8'd50;
          3'd6: d.op = 8'd51;
          3'd7: d.op = 8'd52;
          default: ok = 1'b0;
        endcase
      end
      OPC_JAL: begin
        d.rs1 = 5'd0;
        d.imm = imm_j;
        d.op  = 8'd53;
      end
      OPC_JALR: begin
        d.imm = imm_i;
        d.op  = 8'd54;
        ok    = (f3 == 3'd0);
      end
      OPC_LUI, OPC_AUIPC: begin
        d.rs1 = 5'd0;
        d.imm = imm_u;
        d.op  = (opc == OPC_LUI) ? 8'd55 : 8'd56;
      end
      OPC_SYSTEM: begin
        d.rd  = 5'd0;
        d.rs1 = 5'd0;
        if (i == 32'h0000_0073) d.op = 8'd57;
        else if (i == 32'h0010_0073) d.op = 8'd58;
        else ok = 1'b0;
      end
      OPC_LOAD: begin
        d.imm = imm_i;
        case (f3)
          3'd0: d.op = 8'd59;
          3'd1: d.op = 8'd60;
          3'd2: d.op = 8'd61;
          3'd3: d.op = 8'd65;
          3'd4: d.op = 8'd62;
          3'd5: d.op = 8'd63;
          3'd6: d.op = 8'd64;
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    // Illegal bundles carry only the PC so execute sees clean operands.
    if (!ok) begin
      d.op      = ILL_OP;
      d.rd      = 5'd0;
      d.rs1     = 5'd0;
      d.rs2     = 5'd0;
      d.imm     = '0;
      d.shamt   = '0;
      d.illegal = 1'b1;
    end
  end

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      q         <= '0;
      out_valid <= 1'b0;
      ill_count <= 16'd0;
    end else begin
      if (out_valid && out_ready && q.illegal && !flush &&
          ill_count != 16'hFFFF)
        ill_count <= ill_count + 16'd1;
      if (flush)
        out_valid <= 1'b0;
      else if (in_valid && in_ready) begin
        out_valid <= 1'b1;
        q         <= d;
      end else if (out_ready)
        out_valid <= 1'b0;
    end
  end

  assign out_op      = q.op;
  assign out_rd      = q.rd;
  assign out_rs1     = q.rs1;
  assign out_rs2     = q.rs2;
  assign out_imm     = q.imm;
  assign out_shamt   = q.shamt;
  assign out_pc      = q.pc;
  assign out_illegal = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table streamed back-to-back,
// then stall, flush, illegal-count and reset sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc, out_imm, out_shamt, out_pc;
  logic [7:0]  out_op;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_illegal;
  logic [15:0] ill_count;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm), .out_shamt(out_shamt),
    .out_pc(out_pc), .out_illegal(out_illegal), .ill_count(ill_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic [63:0] shamt;
    logic        ill;
  } vec_t;

  localparam int N = 19;
  vec_t v[N];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bundle(input vec_t e, input logic [63:0] pc);
    chk($sformatf("%08h op", e.instr), out_op, e.op);
    chk($sformatf("%08h rd", e.instr), out_rd, e.rd);
    chk($sformatf("%08h rs1", e.instr), out_rs1, e.rs1);
    chk($sformatf("%08h rs2", e.instr), out_rs2, e.rs2);
    chk($sformatf("%08h imm", e.instr), out_imm, e.imm);
    chk($sformatf("%08h shamt", e.instr), out_shamt, e.shamt);
    chk($sformatf("%08h ill", e.instr), out_illegal, e.ill);
    chk($sformatf("%08h pc", e.instr), out_pc, pc);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, out_valid, 0);
    chk({tag, " ill"}, out_illegal, 0);
    chk({tag, " op"}, out_op, 0);
    chk({tag, " regs"}, {out_rd, out_rs1, out_rs2}, 0);
    chk({tag, " imm"}, out_imm, 0);
    chk({tag, " shamt"}, out_shamt, 0);
    chk({tag, " pc"}, out_pc, 0);
    chk({tag, " cnt"}, ill_count, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    v[0]  = '{32'h002081B3, 8'd0,   5'd3, 5'd1, 5'd2, 64'h0, 64'h0, 1'b0};
    v[1]  = '{32'hFFF30293, 8'd18,  5'd5, 5'd6, 5'd0, '1,    64'h0, 1'b0};
    v[2]  = '{32'h43F0D093, 8'd24,  5'd1, 5'd1, 5'd0, 64'h43F, 64'd63, 1'b0};
    v[3]  = '{32'h402081B3, 8'd1,   5'd3, 5'd1, 5'd2, 64'h0, 64'h0, 1'b0};
    v[4]  = '{32'h022081B3, 8'd10,  5'd3, 5'd1, 5'd2, 64'h0, 64'h0, 1'b0};
    v[5]  = '{32'h0220F1B3, 8'd17,  5'd3, 5'd1, 5'd2, 64'h0, 64'h0, 1'b0};
    v[6]  = '{32'h0020B423, 8'd46,  5'd0, 5'd1, 5'd2, 64'h8, 64'h0, 1'b0};
    v[7]  = '{32'hFE208EE3, 8'd47,  5'd0, 5'd1, 5'd2,
              64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0};
    v[8]  = '{32'h001000EF, 8'd53,  5'd1, 5'd0, 5'd0, 64'h800, 64'h0, 1'b0};
    v[9]  = '{32'h800002B7, 8'd55,  5'd5, 5'd0, 5'd0,
              64'hFFFF_FFFF_8000_0000, 64'h0, 1'b0};
    v[10] = '{32'hFF813383, 8'd65,  5'd7, 5'd2, 5'd0,
              64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1'b0};
    v[11] = '{32'h00000073, 8'd57,  5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0};
    v[12] = '{32'hFFFFFFFF, 8'd255, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 1'b1};
    v[13] = '{32'h80109093, 8'd255, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 1'b1};
    v[14] = '{32'h0200909B, 8'd255, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 1'b1};
    v[15] = '{32'h4050D09B, 8'd32,  5'd1, 5'd1, 5'd0, 64'h405, 64'd5, 1'b0};
    v[16] = '{32'h0220D1BB, 8'd40,  5'd3, 5'd1, 5'd2, 64'h0, 64'h0, 1'b0};
    v[17] = '{32'h00001097, 8'd56,  5'd1, 5'd0, 5'd0, 64'h1000, 64'h0, 1'b0};
    v[18] = '{32'h0020A063, 8'd255, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 1'b1};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_pc = 64'h0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    chk("reset in_ready", in_ready, 1);
    reset = 1'b0;

    // Back-to-back stream: one bundle per cycle, in_ready stays high.
    for (int k = 0; k <= N; k++) begin
      if (k > 0) begin
        chk("stream valid", out_valid, 1);
        chk("stream in_ready", in_ready, 1);
        chk_bundle(v[k-1], 64'h100 + 64'(4 * (k - 1)));
      end
      if (k < N) begin
        in_valid = 1'b1;
        in_instr = v[k].instr;
        in_pc    = 64'h100 + 64'(4 * k);
      end else
        in_valid = 1'b0;
      @(negedge clk);
    end
    chk("drain valid", out_valid, 0);
    chk("table ill_count", ill_count, 4);

    // Stall: bundle held for 3 cycles, then released.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = v[0].instr; in_pc = 64'h200;
    @(negedge clk);
    in_instr = v[1].instr; in_pc = 64'h204;
    for (int c = 0; c < 3; c++) begin
      chk("stall valid", out_valid, 1);
      chk("stall in_ready", in_ready, 0);
      chk_bundle(v[0], 64'h200);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("release in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("after release valid", out_valid, 1);
    chk_bundle(v[1], 64'h204);
    @(negedge clk);
    chk("after release drain", out_valid, 0);

    // Flush with held bundle and concurrent input.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = v[0].instr; in_pc = 64'h300;
    @(negedge clk);
    chk("pre-flush valid", out_valid, 1);
    in_instr = v[9].instr; in_pc = 64'h304; flush = 1'b1;
    #1 chk("flush in_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush valid", out_valid, 0);
    @(negedge clk);
    chk("flush no bundle", out_valid, 0);

    // Illegal encoding handed off three times.
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 64'h400;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ill valid", out_valid, 1);
      chk("ill op", out_op, 255);
      chk("ill flag", out_illegal, 1);
      chk("ill count so far", ill_count, 16'(c));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("ill_count", ill_count, 3);

    // Reset mid-stall discards everything.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = v[2].instr; in_pc = 64'h500;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre-reset valid", out_valid, 1);
    do_reset();
    chk_zero("reset2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
